// File: rtl/riscv_commit_checker.sv
// riscv_commit_checker
// Compares a processor's retired register writes against a preloaded table of
// expected (rd, data) pairs, in order, and reports PASS, FAIL or TIMEOUT.
//
// Ports
//   clk           : single clock, rising edge
//   reset         : asynchronous reset, active low
//   cfg_we/idx/rd/data : load one expected-table entry (ignored while running)
//   start         : single-cycle pulse that begins a check run
//   commit_valid/rd/data/pc : retirement stream from the processor
//   busy          : run in progress
//   done          : run finished (pass, fail or timeout)
//   pass          : run finished with every entry matched
//   err_idx       : table index at failure or timeout
//   err_pc        : pc of the mismatching commit
//   err_data      : data of the mismatching commit
//   cycle_count   : cycles spent running, frozen when the run ends
module riscv_commit_checker #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_CHECKS = 8,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        cfg_we,
    input  logic [((NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1)-1:0] cfg_idx,
    input  logic [4:0]                                  cfg_rd,
    input  logic [XLEN-1:0]                             cfg_data,
    input  logic                                        start,
    input  logic                                        commit_valid,
    input  logic [4:0]                                  commit_rd,
    input  logic [XLEN-1:0]                             commit_data,
    input  logic [XLEN-1:0]                             commit_pc,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        pass,
    output logic [((NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1)-1:0] err_idx,
    output logic [XLEN-1:0]                             err_pc,
    output logic [XLEN-1:0]                             err_data,
    output logic [23:0]                                 cycle_count
);

    localparam int unsigned IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int unsigned CNT_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     err_idx_q, err_idx_d;
    logic [XLEN-1:0]      err_pc_q, err_pc_d;
    logic [XLEN-1:0]      err_data_q, err_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    // Expected-write table; deliberately not reset so a loaded test survives reset.
    logic [4:0]           exp_rd   [NUM_CHECKS];
    logic [XLEN-1:0]      exp_data [NUM_CHECKS];

    logic                 commit_hit_c;
    logic                 entry_match_c;
    logic                 last_entry_c;
    logic                 timeout_hit_c;

    // Table writes are locked out while a run is using the table.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q != S_RUN) && (32'(cfg_idx) < NUM_CHECKS)) begin
            exp_rd[cfg_idx]   <= cfg_rd;
            exp_data[cfg_idx] <= cfg_data;
        end
    end

    // Commits to x0 carry no architectural write and are skipped.
    assign commit_hit_c  = commit_valid && (commit_rd != 5'd0);
    assign entry_match_c = (commit_rd == exp_rd[ptr_q]) && (commit_data == exp_data[ptr_q]);
    assign last_entry_c  = (ptr_q == IDX_W'(NUM_CHECKS - 1));
    assign timeout_hit_c = (count_q == CNT_W'(TIMEOUT - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        err_idx_d  = err_idx_q;
        err_pc_d   = err_pc_q;
        err_data_d = err_data_q;

        case (state_q)
            S_RUN: begin
                // A deciding commit outranks the timeout on the same edge.
                if (commit_hit_c && !entry_match_c) begin
                    state_d    = S_FAIL;
                    err_idx_d  = ptr_q;
                    err_pc_d   = commit_pc;
                    err_data_d = commit_data;
                end else if (commit_hit_c && last_entry_c) begin
                    state_d = S_PASS;
                end else if (timeout_hit_c) begin
                    state_d   = S_TIMEOUT;
                    err_idx_d = ptr_q;
                end else begin
                    if (commit_hit_c) begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                    // Counter only advances while the run continues, so it freezes on exit.
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d    = S_RUN;
                    ptr_d      = '0;
                    count_d    = '0;
                    err_idx_d  = '0;
                    err_pc_d   = '0;
                    err_data_d = '0;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
        pass_d = (state_d == S_PASS);
        done_d = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            err_idx_q  <= '0;
            err_pc_q   <= '0;
            err_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            err_idx_q  <= err_idx_d;
            err_pc_q   <= err_pc_d;
            err_data_q <= err_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_idx     = err_idx_q;
    assign err_pc      = err_pc_q;
    assign err_data    = err_data_q;
    assign cycle_count = count_q;

endmodule
